snake_body_tracker: RTL

Parametrised snake-body store and mover; replaces the fixed 4-segment shift-register pair with one block.
- Holds up to MAX_LEN segment positions, head at index 0.
- Advances the head one cell per step request and supports growth.
- Rejects direction reversal, detects wall and self-collision with a sequential scan.
- Exposes a random-access read port for the VGA draw/erase FSM.

---
 rtl/snake_pkg.sv | 26 ++
 rtl/snake_next_head.sv | 56 +++++
 rtl/snake_body_tracker.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/snake_pkg.sv
// Shared encodings and default screen geometry for the snake game blocks
// (body tracker, draw FSM, apple logic).
package snake_pkg;

  localparam logic [1:0] DIR_RIGHT = 2'd0;
  localparam logic [1:0] DIR_DOWN  = 2'd1;
  localparam logic [1:0] DIR_UP    = 2'd2;
  localparam logic [1:0] DIR_LEFT  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_CHECK = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int SEG_DEF     = 10;
  localparam int XSCREEN_DEF = 160;
  localparam int YSCREEN_DEF = 120;

  // Opposite directions always sum to 3 with this encoding.
  function automatic logic is_reversal(input logic [1:0] a, input logic [1:0] b);
    return (({1'b0, a} + {1'b0, b}) == 3'd3);
  endfunction

endpackage

// File: rtl/snake_next_head.sv
// Next head position one cell along dir, with screen-range check.
// SNAKE_WRAP_EN selects wrap-around at the edges instead of reporting out_of_range.
module snake_next_head
  import snake_pkg::*;
#(
  parameter int XW      = 8,
  parameter int YW      = 7,
  parameter int SEG     = SEG_DEF,
  parameter int XSCREEN = XSCREEN_DEF,
  parameter int YSCREEN = YSCREEN_DEF
) (
  input  logic [XW-1:0] head_x,
  input  logic [YW-1:0] head_y,
  input  logic [1:0]    dir,
  output logic [XW-1:0] next_x,
  output logic [YW-1:0] next_y,
  output logic          out_of_range
);

  localparam logic signed [XW:0] STEP_X = (XW+1)'(SEG);
  localparam logic signed [YW:0] STEP_Y = (YW+1)'(SEG);
  localparam logic signed [XW:0] MAX_X  = (XW+1)'(XSCREEN - SEG);
  localparam logic signed [YW:0] MAX_Y  = (YW+1)'(YSCREEN - SEG);

  logic signed [XW:0] sum_x;
  logic signed [YW:0] sum_y;
  logic x_low, x_high, y_low, y_high;

  // One extra signed bit so a step below zero shows up as a negative value.
  always_comb begin
    sum_x = $signed({1'b0, head_x});
    sum_y = $signed({1'b0, head_y});
    case (dir)
      DIR_RIGHT: sum_x = sum_x + STEP_X;
      DIR_DOWN:  sum_y = sum_y + STEP_Y;
      DIR_UP:    sum_y = sum_y - STEP_Y;
      default:   sum_x = sum_x - STEP_X;
    endcase
  end

  assign x_low  = sum_x[XW];
  assign y_low  = sum_y[YW];
  assign x_high = (sum_x > MAX_X);
  assign y_high = (sum_y > MAX_Y);

`ifdef SNAKE_WRAP_EN
  assign next_x = x_low ? MAX_X[XW-1:0] : (x_high ? '0 : sum_x[XW-1:0]);
  assign next_y = y_low ? MAX_Y[YW-1:0] : (y_high ? '0 : sum_y[YW-1:0]);
  assign out_of_range = 1'b0;
`else
  assign next_x = sum_x[XW-1:0];
  assign next_y = sum_y[YW-1:0];
  assign out_of_range = x_low | x_high | y_low | y_high;
`endif

endmodule

// File: rtl/snake_body_tracker.sv
// Snake body store and mover: head at index 0, step/grow, wall and self-collision scan.
// Define SNAKE_WRAP_EN to wrap the head at screen edges instead of flagging a wall hit.
module snake_body_tracker
  import snake_pkg::*;
#(
  parameter int XW       = 8,
  parameter int YW       = 7,
  parameter int MAX_LEN  = 16,
  parameter int INIT_LEN = 4,
  parameter int SEG      = SEG_DEF,
  parameter int XSCREEN  = XSCREEN_DEF,
  parameter int YSCREEN  = YSCREEN_DEF,
  parameter int X0       = 80,
  parameter int Y0       = 60,
  localparam int IW      = $clog2(MAX_LEN),
  localparam int LW      = $clog2(MAX_LEN + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          init,
  input  logic          step,
  input  logic [1:0]    dir,
  input  logic          grow,
  output logic          ready,
  output logic          done,
  input  logic [IW-1:0] rd_idx,
  output logic [XW-1:0] rd_x,
  output logic [YW-1:0] rd_y,
  output logic          rd_valid,
  output logic [LW-1:0] length,
  output logic          full,
  output logic          collision,
  output logic          wall_hit,
  output logic [1:0]    cur_dir,
  output logic [1:0]    dbg_state
);

  // Valid/ready: a step is taken on a clock edge where step=1 and ready=1;
  // step while ready=0 is dropped, and done pulses once when that step finishes.

  localparam int DEPTH = 1 << IW;
  localparam logic [LW-1:0] INIT_LEN_L = LW'(INIT_LEN);
  localparam logic [LW-1:0] MAX_LEN_L  = LW'(MAX_LEN);

  state_t        state;
  logic [XW-1:0] seg_x [DEPTH];
  logic [YW-1:0] seg_y [DEPTH];
  logic [LW-1:0] len;
  logic [IW-1:0] idx;
  logic [IW-1:0] last_idx;
  logic [1:0]    eff_dir;
  logic          grow_q;
  logic [XW-1:0] next_x;
  logic [YW-1:0] next_y;
  logic          out_of_range;

  snake_next_head #(
    .XW      (XW),
    .YW      (YW),
    .SEG     (SEG),
    .XSCREEN (XSCREEN),
    .YSCREEN (YSCREEN)
  ) u_next_head (
    .head_x       (seg_x[0]),
    .head_y       (seg_y[0]),
    .dir          (eff_dir),
    .next_x       (next_x),
    .next_y       (next_y),
    .out_of_range (out_of_range)
  );

  assign last_idx = IW'(len - 1'b1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        seg_x[i] <= (i < INIT_LEN) ? XW'(X0) : '0;
        seg_y[i] <= (i < INIT_LEN) ? YW'(Y0 + i * SEG) : '0;
      end
      len       <= INIT_LEN_L;
      cur_dir   <= DIR_UP;
      eff_dir   <= DIR_UP;
      grow_q    <= 1'b0;
      idx       <= '0;
      collision <= 1'b0;
      wall_hit  <= 1'b0;
      done      <= 1'b0;
      state     <= ST_IDLE;
    end else if (init) begin
      for (int i = 0; i < DEPTH; i++) begin
        seg_x[i] <= (i < INIT_LEN) ? XW'(X0) : '0;
        seg_y[i] <= (i < INIT_LEN) ? YW'(Y0 + i * SEG) : '0;
      end
      len       <= INIT_LEN_L;
      cur_dir   <= DIR_UP;
      eff_dir   <= DIR_UP;
      grow_q    <= 1'b0;
      idx       <= '0;
      collision <= 1'b0;
      wall_hit  <= 1'b0;
      done      <= 1'b0;
      state     <= ST_IDLE;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (step && ready) begin
            eff_dir <= is_reversal(dir, cur_dir) ? cur_dir : dir;
            grow_q  <= grow;
            state   <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (out_of_range) begin
            wall_hit <= 1'b1;
            done     <= 1'b1;
            state    <= ST_DONE;
          end else begin
            for (int i = 1; i < MAX_LEN; i++) begin
              seg_x[i] <= seg_x[i-1];
              seg_y[i] <= seg_y[i-1];
            end
            seg_x[0] <= next_x;
            seg_y[0] <= next_y;
            cur_dir  <= eff_dir;
            if (grow_q && (len < MAX_LEN_L)) len <= len + 1'b1;
            idx   <= IW'(1);
            state <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          // Fixed-length scan over the body so latency depends only on length.
          if ((seg_x[idx] == seg_x[0]) && (seg_y[idx] == seg_y[0])) collision <= 1'b1;
          if (idx == last_idx) begin
            done  <= 1'b1;
            state <= ST_DONE;
          end
          idx <= idx + 1'b1;
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign ready     = (state == ST_IDLE) && !collision && !wall_hit;
  assign rd_x      = seg_x[rd_idx];
  assign rd_y      = seg_y[rd_idx];
  assign rd_valid  = (LW'(rd_idx) < len);
  assign length    = len;
  assign full      = (len == MAX_LEN_L);
  assign dbg_state = state;

endmodule
